// File: rtl/nrdiv_pkg.sv
// Shared types and constants for the nr_div32 iterative divider.
package nrdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } nrdiv_state_e;

  localparam int NRDIV_WIDTH = 32;
  localparam int NRDIV_MAX_W = 64;

  function automatic int nrdiv_cnt_w(input int w);
    return $clog2(w);
  endfunction

  localparam int NRDIV_CNT_W = nrdiv_cnt_w(NRDIV_WIDTH);

  // Quotient reported on divide-by-zero; sliced to the operand width by the user.
  localparam logic [NRDIV_MAX_W-1:0] NRDIV_DZ_Q = '1;

endpackage

// File: rtl/nr_div_step.sv
// One combinational non-restoring iteration: shift in a dividend bit, then add or subtract the divisor.
module nr_div_step
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = NRDIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             din_i,
  input  logic             sub_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] operand;

  assign shifted = {rem_i[WIDTH-1:0], din_i};
  // Subtraction as add of the inverted divisor with carry-in set.
  assign operand = {1'b0, dvs_i} ^ {(WIDTH+1){sub_i}};
  assign rem_o   = shifted + operand + {{WIDTH{1'b0}}, sub_i};
  assign qbit_o  = ~rem_o[WIDTH];

endmodule

// File: rtl/nr_div32.sv
// Iterative non-restoring divider for DIV/DIVU/REM/REMU; one iteration per clock.
// Signed operation is built only when NRDIV_SIGNED_EN is defined; otherwise every operation is unsigned.
module nr_div32
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = NRDIV_WIDTH
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             sign,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             ready,
  output logic             dz
);

  localparam int CNT_W = nrdiv_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  nrdiv_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             dzp_q, dzp_d, dz_q, dz_d, ready_q, ready_d;

  logic [WIDTH-1:0] a_mag, b_mag, rem_mag, quo_fix, rem_fix;
  logic [WIDTH:0]   step_rem;
  logic             step_qbit;
  logic             accept;

  assign accept = (state_q == IDLE) && start && !cancel;

  nr_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (prem_q),
    .dvs_i  (dvs_q),
    .din_i  (dvd_q[WIDTH-1]),
    .sub_i  (~prem_q[WIDTH]),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  // A negative final partial remainder gets the divisor added back once.
  assign rem_mag = prem_q[WIDTH] ? (prem_q[WIDTH-1:0] + dvs_q) : prem_q[WIDTH-1:0];

`ifdef NRDIV_SIGNED_EN
  logic a_neg, b_neg, qneg_q, rneg_q;

  assign a_neg   = sign & a[WIDTH-1];
  assign b_neg   = sign & b[WIDTH-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign quo_fix = qneg_q ? -dvd_q : dvd_q;
  assign rem_fix = rneg_q ? -rem_mag : rem_mag;

  always_ff @(posedge clk) begin
    if (accept) begin
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
    end
  end
`else
  logic unused_sign;

  assign unused_sign = sign;
  assign a_mag       = a;
  assign b_mag       = b;
  assign quo_fix     = dvd_q;
  assign rem_fix     = rem_mag;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    dzp_d   = dzp_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          prem_d = '0;
          cnt_d  = '0;
          dvs_d  = b_mag;
          // Divide-by-zero keeps the raw dividend so it can be returned as the remainder.
          if (b == '0) begin
            dvd_d   = a;
            dzp_d   = 1'b1;
            state_d = FIX;
          end else begin
            dvd_d   = a_mag;
            dzp_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          prem_d = step_rem;
          dvd_d  = {dvd_q[WIDTH-2:0], step_qbit};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          ready_d = 1'b1;
          dz_d    = dzp_q;
          if (dzp_q) begin
            quo_d = NRDIV_DZ_Q[WIDTH-1:0];
            rem_d = dvd_q;
          end else begin
            quo_d = quo_fix;
            rem_d = rem_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dzp_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dzp_q   <= dzp_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    prem_q <= prem_d;
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
  end

  assign q     = quo_q;
  assign r     = rem_q;
  assign dz    = dz_q;
  assign ready = ready_q;
  assign busy  = (state_q != IDLE);

endmodule
